// File: rtl/sparsity_mode_switch_seq.sv
// Sparsity-mode switch sequencer.
//
// Sequences a mode change requested by the adaptive sparsity FSM onto the sparse MAC datapath:
// it stalls tile issue, waits for in-flight tiles to drain, writes the new mode on the config
// port and waits for an acknowledge (with a timeout), then holds the stall for a settle period
// before releasing it. Requests that arrive while busy are kept as a single pending request,
// with the most recent one winning.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   mode_change_pulse   one-cycle request; target_mode is sampled with it
//   target_mode         requested mode (0=dense, 1=2:4, 2=1:4, 3=1:8)
//   tile_issue/retire   datapath issued / retired one tile this cycle
//   cfg_ack             datapath accepted cfg_mode
//   err_clear           clears timeout_err
//   issue_stall         blocks new tile issue
//   cfg_valid/cfg_mode  config write request and the mode being written
//   active_mode         mode currently applied in the datapath
//   busy                sequencer is not idle
//   inflight_count      tiles in flight (saturating)
//   timeout_err         sticky config-timeout flag
//   switch_count        completed switches (wraps)
module sparsity_mode_switch_seq #(
  parameter int unsigned INFLIGHT_W     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode_change_pulse,
  input  logic [1:0]            target_mode,
  input  logic                  tile_issue,
  input  logic                  tile_retire,
  input  logic                  cfg_ack,
  input  logic                  err_clear,
  output logic                  issue_stall,
  output logic                  cfg_valid,
  output logic [1:0]            cfg_mode,
  output logic [1:0]            active_mode,
  output logic                  busy,
  output logic [INFLIGHT_W-1:0] inflight_count,
  output logic                  timeout_err,
  output logic [15:0]           switch_count
);

  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [INFLIGHT_W-1:0] InflightMax = '1;
  localparam logic [TmoW-1:0]       TmoLast     = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [SettleW-1:0]    SettleInit  = SettleW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrain, StConfig, StSettle} state_e;

  state_e              state_q;
  logic [1:0]          req_mode_q;
  logic                pending_q;
  logic [1:0]          pending_mode_q;
  logic [TmoW-1:0]     tmo_cnt_q;
  logic [SettleW-1:0]  settle_cnt_q;

  // A pulse on the SETTLE exit cycle takes part in the exit decision.
  logic       exit_pending;
  logic [1:0] exit_mode;

  always_comb begin
    exit_pending = pending_q;
    exit_mode    = pending_mode_q;
    if (mode_change_pulse) begin
      exit_pending = 1'b1;
      exit_mode    = target_mode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      issue_stall    <= 1'b0;
      cfg_valid      <= 1'b0;
      cfg_mode       <= 2'd0;
      active_mode    <= 2'd0;
      busy           <= 1'b0;
      inflight_count <= '0;
      timeout_err    <= 1'b0;
      switch_count   <= 16'd0;
      req_mode_q     <= 2'd0;
      pending_q      <= 1'b0;
      pending_mode_q <= 2'd0;
      tmo_cnt_q      <= '0;
      settle_cnt_q   <= '0;
    end else begin
      // In-flight tracking runs in every state; simultaneous issue and retire cancel.
      if (tile_issue && !tile_retire && inflight_count != InflightMax) begin
        inflight_count <= inflight_count + INFLIGHT_W'(1);
      end else if (!tile_issue && tile_retire && inflight_count != '0) begin
        inflight_count <= inflight_count - INFLIGHT_W'(1);
      end

      if (state_q != StIdle && mode_change_pulse) begin
        pending_q      <= 1'b1;
        pending_mode_q <= target_mode;
      end

      // A timeout set later in this block overrides the clear.
      if (err_clear) begin
        timeout_err <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (mode_change_pulse && target_mode != active_mode) begin
            req_mode_q  <= target_mode;
            state_q     <= StDrain;
            issue_stall <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StDrain: begin
          if (inflight_count == '0) begin
            state_q   <= StConfig;
            cfg_valid <= 1'b1;
            cfg_mode  <= req_mode_q;
            tmo_cnt_q <= '0;
          end
        end
        StConfig: begin
          if (cfg_ack) begin
            cfg_valid    <= 1'b0;
            active_mode  <= req_mode_q;
            switch_count <= switch_count + 16'd1;
            state_q      <= StSettle;
            settle_cnt_q <= SettleInit;
          end else if (tmo_cnt_q == TmoLast) begin
            cfg_valid   <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= StIdle;
            issue_stall <= 1'b0;
            busy        <= 1'b0;
            pending_q   <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StSettle: begin
          if (settle_cnt_q == '0) begin
            pending_q <= 1'b0;
            if (exit_pending && exit_mode != active_mode) begin
              // Chain straight into the next switch; stall stays asserted.
              req_mode_q <= exit_mode;
              state_q    <= StDrain;
            end else begin
              state_q     <= StIdle;
              issue_stall <= 1'b0;
              busy        <= 1'b0;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q - SettleW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/sparsity_mode_switch_seq.md
Name: sparsity_mode_switch_seq

Overview:
Sequences a sparsity-mode change requested by the adaptive sparsity FSM onto the sparse MAC datapath.
- On a mode-change request it stalls tile issue and drains in-flight tiles.
- It then writes the new mode to the datapath config port and waits for acknowledge, with a timeout.
- After a settle period it releases the stall.
- It sits between the FSM outputs (mode_change_pulse / current_mode) and the datapath issue/config interface.

Parameters:
INFLIGHT_W, 5, width of in-flight tile counter; saturates at 2^INFLIGHT_W-1
TIMEOUT_CYCLES, 1023, max cycles in CONFIG waiting for cfg_ack (>=1)
SETTLE_CYCLES, 4, cycles held in SETTLE after ack before stall release (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mode_change_pulse  in  1  one-cycle request from the sparsity FSM
target_mode  in  2  requested mode (0=dense, 1=2:4, 2=1:4, 3=1:8); sampled with the pulse
tile_issue  in  1  datapath issued one tile this cycle
tile_retire  in  1  datapath retired one tile this cycle
cfg_ack  in  1  datapath accepted cfg_mode
err_clear  in  1  clears timeout_err
issue_stall  out  1  blocks new tile issue
cfg_valid  out  1  config write request
cfg_mode  out  2  mode being written
active_mode  out  2  mode currently applied in the datapath
busy  out  1  state != IDLE
inflight_count  out  INFLIGHT_W  tiles in flight
timeout_err  out  1  sticky config-timeout flag
switch_count  out  16  completed switches; wraps at 16'hFFFF->0

Behaviour:
- Reset (async): state=IDLE; issue_stall=0; cfg_valid=0; cfg_mode=0; active_mode=0; inflight_count=0; timeout_err=0; switch_count=0; pending flag cleared.
- All outputs are registered.
- In-flight counter, updated every cycle in all states:
  - issue & retire: no change.
  - issue only: +1, saturating at max.
  - retire only: -1; retire at 0 is ignored (no underflow).
- States: IDLE, DRAIN, CONFIG, SETTLE.
- IDLE:
  - Pulse with target_mode != active_mode: latch req_mode. Next cycle state=DRAIN, issue_stall=1.
  - Pulse with target_mode == active_mode: ignored.
- DRAIN:
  - When inflight_count==0 (registered value), next state=CONFIG.
  - Load cfg_mode=req_mode, cfg_valid=1, reset the timeout counter.
  - A tile_issue arriving on the cycle stall first asserts is still counted.
- CONFIG:
  - cfg_valid is held high, and cfg_mode held stable, until cfg_ack.
  - cfg_ack on the same cycle cfg_valid is high counts as accepted.
  - On ack: next cycle cfg_valid=0, active_mode=req_mode, switch_count+1, state=SETTLE, settle counter=SETTLE_CYCLES-1.
  - If TIMEOUT_CYCLES cycles elapse in CONFIG without ack:
    - cfg_valid=0, timeout_err=1, active_mode unchanged, switch_count unchanged.
    - state=IDLE, issue_stall=0.
    - The pending flag is discarded.
- SETTLE:
  - Stall stays high; the counter decrements each cycle.
  - At 0 with no valid pending request: state=IDLE, issue_stall=0.
  - If a pending request exists with pending_mode != active_mode: req_mode=pending_mode, pending cleared, state=DRAIN, and issue_stall stays high (no release gap).
- Pulse while busy (DRAIN/CONFIG/SETTLE):
  - Stores pending_mode=target_mode and sets pending; a later pulse overwrites it (latest wins).
  - The request in progress is never aborted.
  - A pulse on the exact cycle SETTLE exits is treated as pending and evaluated in that exit decision.
- timeout_err:
  - Cleared by err_clear.
  - If err_clear and a new timeout occur in the same cycle, the set wins.
- Minimum latency, pulse at cycle 0 with inflight=0:
  - DRAIN at cycle 1.
  - cfg_valid=1 at cycle 2.
  - With ack at cycle 2: active_mode updated at cycle 3.
  - issue_stall=0 at cycle 3+SETTLE_CYCLES.
- Reset mid-operation: immediate return to reset values; pending request lost.

Test Plan:
- Reset, pulse target_mode=2 with inflight=0, cfg_ack on the first cfg_valid cycle -> stall at cycle 1, cfg_valid/cfg_mode=2 at cycle 2, active_mode=2 at cycle 3, stall=0 at cycle 7 (SETTLE_CYCLES=4), switch_count=1.
- Issue 3 tiles, pulse mode 1, retire one tile every 5 cycles -> cfg_valid asserts only after inflight_count reaches 0; simultaneous issue+retire leaves the count unchanged; a retire at 0 keeps it 0.
- Pulse mode 3, never ack (TIMEOUT_CYCLES=8) -> cfg_valid drops after 8 CONFIG cycles, timeout_err=1, active_mode unchanged, stall=0; err_clear -> timeout_err=0.
- Pulse mode 1, then pulses mode 2 and mode 3 during DRAIN -> after the mode-1 settle, goes straight to DRAIN with stall held, ends with active_mode=3, switch_count=2.
- Pulse with target_mode == active_mode in IDLE -> no stall, no cfg_valid, switch_count unchanged; a pending mode equal to active_mode at SETTLE exit -> returns to IDLE.
- Assert reset during CONFIG with cfg_valid high -> all outputs at reset values the same cycle; a fresh pulse afterwards completes normally.
